ins_prefetch_queue: RTL and testbench
=====================================

Name: ins_prefetch_queue

Overview:
- Parametrised instruction-fetch front end for the 8051 core.
- Generalises the single-byte fetch path: runs back-to-back program-memory reads over the external bus with a configurable number of wait states, and buffers fetched bytes in a DEPTH-entry queue.
- Presents bytes to the decoder with a valid/ready handshake.
- Sits between the CPU decoder and the external addr_bus/data_bus; supports flush on jump.

Parameters:
- DATA_W, 8, width of data_bus and of each queued instruction byte.
- ADDR_W, 16, width of addr_bus and of the program counter.
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- WAIT_STATES, 1, extra cycles read_en is held before data_bus is sampled; range 0..7.
- RESET_PC, 0, fetch address loaded at reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr_bus  output  ADDR_W  fetch address; valid while read_en=1.
- data_bus  input  DATA_W  read data from program memory.
- read_en  output  1  bus read strobe.
- memory_select  output  1  memory space select; constant 0 (program memory).
- ins_valid  output  1  queue head holds a valid byte.
- ins_data  output  DATA_W  byte at queue head.
- ins_pc  output  ADDR_W  address the head byte was fetched from.
- ins_ready  input  1  decoder accepts the head byte this cycle.
- jump_en  input  1  flush the queue and redirect fetch.
- jump_addr  input  ADDR_W  new fetch address; used when jump_en=1.
- fetch_hold  input  1  block new bus reads; an in-flight read completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - read_en=0, addr_bus=0, ins_valid=0, ins_data=0, ins_pc=0, memory_select=0.
  - Queue count=0; FSM=IDLE; fetch_pc=RESET_PC.
- FSM states: IDLE, READ, WAIT.
  - IDLE -> READ when fetch_hold=0, jump_en=0 and count < DEPTH.
  - On entry to READ: read_en=1 and addr_bus=fetch_pc, registered.
  - READ: if WAIT_STATES=0, sample data_bus this cycle, push, and leave READ. Otherwise go to WAIT with wait counter=WAIT_STATES-1.
  - WAIT: read_en stays 1. Counter decrements each cycle. When counter=0, sample data_bus and push.
  - After the sample: fetch_pc increments modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
  - After the sample, if the IDLE->READ conditions still hold (count after push < DEPTH, fetch_hold=0), go directly to READ with the new address. Reads run back-to-back with no idle cycle. Otherwise go to IDLE with read_en=0.
- Bus read length: each read holds read_en high for WAIT_STATES+1 cycles. addr_bus is stable for the whole read.
- Overflow avoidance: a read is started only when count < DEPTH, so the in-flight slot is always reserved.
- Pop: pop occurs when ins_valid=1 and ins_ready=1.
  - Push and pop in the same cycle leave count unchanged.
  - ins_ready while ins_valid=0 is ignored.
- Fetch latency: the first byte after reset or a jump reaches ins_valid=1 exactly WAIT_STATES+2 cycles after read_en first rises.
- Flush: jump_en=1 at a clock edge does all of the following:
  - count=0, ins_valid=0.
  - Any in-flight read is aborted: read_en=0 next cycle and data is discarded.
  - fetch_pc=jump_addr; FSM=IDLE.
  - A pop in the same cycle is ignored (jump wins).
  - Fetch resumes from jump_addr the cycle after jump_en falls.
  - Back-to-back jump_en cycles: the last jump_addr wins.
- fetch_hold=1:
  - No new READ is entered.
  - An in-flight read completes and pushes normally.
  - Popping continues.
- ins_pc: carries the address stored alongside each byte, wrapping as fetch_pc wraps.
- Reset mid-read: read_en drops asynchronously and all queue contents are lost.

Test Plan:
- Reset, WAIT_STATES=1, memory returns 0xC3,0xB4,0x50,0x22 at 0x0000-0x0003, ins_ready=0:
  - read_en pulses are 2 cycles each on addresses 0..3, back-to-back.
  - Fetching stops with count=4; head is 0xC3 with ins_pc=0x0000.
- Queue full, ins_ready held 1:
  - One byte is popped per cycle in order 0xC3,0xB4,0x50,0x22.
  - A refill read at 0x0004 starts the cycle after the first pop.
- Jump mid-read: jump_en=1 with jump_addr=0x0100 during a WAIT cycle at 0x0002:
  - read_en=0 next cycle, ins_valid=0.
  - Next read is at 0x0100; the first ins_pc after the jump is 0x0100.
- Wrap-around: jump to 0xFFFE, DEPTH=4:
  - Fetch addresses are 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - ins_pc follows the same sequence.
- WAIT_STATES=0, ins_ready=1 permanently:
  - read_en stays high continuously and addr_bus increments every cycle.
  - After initial latency, ins_valid=1 every cycle and count never exceeds 1.
- fetch_hold=1 asserted during a WAIT cycle: the current byte is pushed, no further read_en pulse occurs, and fetching resumes after fetch_hold=0.

Source files
------------

// File: rtl/ins_prefetch_queue.sv
// Instruction prefetch front end: back-to-back program-memory reads with wait
// states feeding a small byte queue drained by the decoder over valid/ready.
module ins_prefetch_queue #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 4,
  parameter int WAIT_STATES = 1,
  parameter int RESET_PC    = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] addr_bus,
  input  logic [DATA_W-1:0] data_bus,
  output logic              read_en,
  output logic              memory_select,
  output logic              ins_valid,
  output logic [DATA_W-1:0] ins_data,
  output logic [ADDR_W-1:0] ins_pc,
  input  logic              ins_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              fetch_hold
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [2:0] WAIT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        wait_cnt_reg, wait_cnt_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              read_en_reg, read_en_next;

  logic              cap_valid_reg;
  logic [DATA_W-1:0] cap_data_reg;
  logic [ADDR_W-1:0] cap_pc_reg;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next, occ_next;

  logic sample, push, pop, start_ok;

  // The last bus cycle of a read; data_bus is captured at its closing edge.
  assign sample = !jump_en &&
                  (((state_reg == S_READ) && (WAIT_STATES == 0)) ||
                   ((state_reg == S_WAIT) && (wait_cnt_reg == 3'd0)));

  assign push = cap_valid_reg && !jump_en;
  assign pop  = ins_valid && ins_ready && !jump_en;

  // occ_next counts queued bytes plus the captured byte still on its way in,
  // so a new read only starts when its destination slot is guaranteed.
  assign count_next = jump_en ? '0 : (count_reg + CNT_W'(push) - CNT_W'(pop));
  assign occ_next   = count_next + CNT_W'(sample);
  assign start_ok   = !fetch_hold && !jump_en && (occ_next < DEPTH_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 3'd0;
      fetch_pc_reg <= ADDR_W'(RESET_PC);
      addr_reg     <= '0;
      read_en_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      fetch_pc_reg <= fetch_pc_next;
      addr_reg     <= addr_next;
      read_en_reg  <= read_en_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      S_IDLE: if (start_ok) state_next = S_READ;
      S_READ: begin
        if (WAIT_STATES == 0) begin
          state_next = start_ok ? S_READ : S_IDLE;
        end else begin
          state_next    = S_WAIT;
          wait_cnt_next = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_reg == 3'd0) state_next = start_ok ? S_READ : S_IDLE;
        else wait_cnt_next = wait_cnt_reg - 3'd1;
      end
      default: state_next = S_IDLE;
    endcase
    if (jump_en) state_next = S_IDLE;
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (jump_en) fetch_pc_next = jump_addr;
    else if (sample) fetch_pc_next = fetch_pc_reg + ADDR_W'(1);
    read_en_next = (state_next != S_IDLE);
    case (state_next)
      S_READ:  addr_next = fetch_pc_next;
      S_WAIT:  addr_next = addr_reg;
      default: addr_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_valid_reg <= 1'b0;
      cap_data_reg  <= '0;
      cap_pc_reg    <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
    end else begin
      cap_valid_reg <= sample;
      if (sample) begin
        cap_data_reg <= data_bus;
        cap_pc_reg   <= addr_reg;
      end
      count_reg <= count_next;
      if (jump_en) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W-1:0] pc_reg;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_reg <= '0;
        pc_reg   <= '0;
      end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        data_reg <= cap_data_reg;
        pc_reg   <= cap_pc_reg;
      end
    end
    assign data_q[gi] = data_reg;
    assign pc_q[gi]   = pc_reg;
  end

  assign addr_bus      = addr_reg;
  assign read_en       = read_en_reg;
  assign memory_select = 1'b0;
  assign ins_valid     = (count_reg != '0);
  assign ins_data      = data_q[rd_ptr_reg];
  assign ins_pc        = pc_q[rd_ptr_reg];

endmodule

// File: tb/tb_ins_prefetch_queue.sv
// Bench for ins_prefetch_queue: WAIT_STATES=1 instance driven through fill,
// drain, jump, wrap and hold scenarios, plus a WAIT_STATES=0 streaming instance.
module tb_ins_prefetch_queue;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr_bus;
  logic [7:0]  data_bus;
  logic        read_en;
  logic        memory_select;
  logic        ins_valid;
  logic [7:0]  ins_data;
  logic [15:0] ins_pc;
  logic        ins_ready = 1'b0;
  logic        jump_en = 1'b0;
  logic [15:0] jump_addr = 16'h0000;
  logic        fetch_hold = 1'b0;

  logic [15:0] z_addr_bus;
  logic [7:0]  z_data_bus;
  logic        z_read_en;
  logic        z_memory_select;
  logic        z_ins_valid;
  logic [7:0]  z_ins_data;
  logic [15:0] z_ins_pc;
  logic        z_ins_ready = 1'b1;
  logic        z_jump_en = 1'b0;
  logic [15:0] z_jump_addr = 16'h0000;
  logic        z_fetch_hold = 1'b0;
  logic        z_done = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int reads_started = 0;
  int rd_high_cnt = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  data;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0000: return 8'hC3;
      16'h0001: return 8'hB4;
      16'h0002: return 8'h50;
      16'h0003: return 8'h22;
      default:  return a[7:0] ^ a[15:8] ^ 8'h3C;
    endcase
  endfunction

  assign data_bus   = mem_byte(addr_bus);
  assign z_data_bus = mem_byte(z_addr_bus);

  ins_prefetch_queue #(.DATA_W(8), .ADDR_W(16), .DEPTH(4), .WAIT_STATES(WS), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .addr_bus(addr_bus), .data_bus(data_bus),
    .read_en(read_en), .memory_select(memory_select), .ins_valid(ins_valid),
    .ins_data(ins_data), .ins_pc(ins_pc), .ins_ready(ins_ready),
    .jump_en(jump_en), .jump_addr(jump_addr), .fetch_hold(fetch_hold)
  );

  ins_prefetch_queue #(.DATA_W(8), .ADDR_W(16), .DEPTH(4), .WAIT_STATES(0), .RESET_PC(0)) dut_ws0 (
    .clk(clk), .reset(reset), .addr_bus(z_addr_bus), .data_bus(z_data_bus),
    .read_en(z_read_en), .memory_select(z_memory_select), .ins_valid(z_ins_valid),
    .ins_data(z_ins_data), .ins_pc(z_ins_pc), .ins_ready(z_ins_ready),
    .jump_en(z_jump_en), .jump_addr(z_jump_addr), .fetch_hold(z_fetch_hold)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_jump(input logic [15:0] a);
    @(posedge clk); #1;
    jump_en = 1'b1;
    jump_addr = a;
    @(posedge clk); #1;
    jump_en = 1'b0;
  endtask

  // Scoreboard: each observed read start pushes the byte the bench expects
  // from its own fetch-address model; each accepted byte pops and compares.
  initial begin
    logic [15:0] exp_pc;
    logic [15:0] cur_addr;
    int rd_cycle;
    sb_t e;
    exp_pc = 16'h0000;
    cur_addr = 16'h0000;
    rd_cycle = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        sb.delete();
        exp_pc = 16'h0000;
        rd_cycle = 0;
      end else begin
        if (ins_valid && ins_ready && !jump_en) begin
          check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            $display("pop  pc=%04h data=%02h  (expected pc=%04h data=%02h)", ins_pc, ins_data, e.pc, e.data);
            check_eq("pop_data", 32'(ins_data), 32'(e.data));
            check_eq("pop_pc", 32'(ins_pc), 32'(e.pc));
          end
        end
        if (read_en) begin
          rd_high_cnt++;
          if (rd_cycle == 0) begin
            $display("read addr=%04h  (expected %04h)", addr_bus, exp_pc);
            check_eq("rd_addr", 32'(addr_bus), 32'(exp_pc));
            sb.push_back('{pc: exp_pc, data: mem_byte(exp_pc)});
            exp_pc = exp_pc + 16'h0001;
            cur_addr = addr_bus;
            reads_started++;
          end else begin
            check_eq("rd_stable", 32'(addr_bus), 32'(cur_addr));
          end
          rd_cycle = (rd_cycle == WS) ? 0 : rd_cycle + 1;
        end else begin
          if (rd_cycle != 0) check_eq("rd_len", 32'(rd_cycle), 32'd0);
          rd_cycle = 0;
        end
        if (jump_en) begin
          sb.delete();
          exp_pc = jump_addr;
          rd_cycle = 0;
        end
      end
    end
  end

  // Zero-wait-state instance streams one byte per cycle with ins_ready tied high.
  initial begin
    for (int i = 0; i < 20 && !reset; i++) @(negedge clk);
    for (int i = 0; i < 20 && !z_read_en; i++) @(negedge clk);
    check_eq("ws0_start", 32'(z_read_en), 32'd1);
    for (int k = 0; k < 30; k++) begin
      check_eq("ws0_rd", 32'(z_read_en), 32'd1);
      check_eq("ws0_addr", 32'(z_addr_bus), 32'(k));
      if (k < 2) begin
        check_eq("ws0_lat", 32'(z_ins_valid), 32'd0);
      end else begin
        check_eq("ws0_valid", 32'(z_ins_valid), 32'd1);
        check_eq("ws0_pc", 32'(z_ins_pc), 32'(k - 2));
        check_eq("ws0_data", 32'(z_ins_data), 32'(mem_byte(16'(k - 2))));
      end
      @(negedge clk);
    end
    z_done = 1'b1;
  end

  initial begin
    int lat;
    int n;
    logic [15:0] wpc;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_read_en", 32'(read_en), 32'd0);
    check_eq("rst_addr", 32'(addr_bus), 32'd0);
    check_eq("rst_valid", 32'(ins_valid), 32'd0);
    check_eq("rst_data", 32'(ins_data), 32'd0);
    check_eq("rst_pc", 32'(ins_pc), 32'd0);
    check_eq("rst_memsel", 32'(memory_select), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Fill with ins_ready low
    for (int i = 0; i < 20 && !read_en; i++) @(negedge clk);
    check_eq("first_rd", 32'(read_en), 32'd1);
    lat = 0;
    for (int i = 0; i < 20 && !ins_valid; i++) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(WS + 2));
    repeat (20) @(negedge clk);
    check_eq("fill_idle", 32'(read_en), 32'd0);
    check_eq("fill_reads", 32'(reads_started), 32'd4);
    check_eq("fill_rd_cycles", 32'(rd_high_cnt), 32'd8);
    check_eq("fill_valid", 32'(ins_valid), 32'd1);
    check_eq("fill_head", 32'(ins_data), 32'hC3);
    check_eq("fill_pc", 32'(ins_pc), 32'd0);

    // Drain with ins_ready high; refill starts right after the first pop
    @(posedge clk); #1;
    ins_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("refill_rd", 32'(read_en), 32'd1);
    check_eq("refill_addr", 32'(addr_bus), 32'h0004);
    repeat (12) @(negedge clk);
    @(posedge clk); #1;
    ins_ready = 1'b0;

    // Jump during the wait cycle of the read at 0x0002
    do_jump(16'h0000);
    for (int i = 0; i < 40 && !(read_en && addr_bus == 16'h0002); i++) @(negedge clk);
    check_eq("jmp_find", 32'(read_en && addr_bus == 16'h0002), 32'd1);
    @(posedge clk); #1;
    jump_en = 1'b1;
    jump_addr = 16'h0100;
    @(posedge clk); #1;
    jump_en = 1'b0;
    @(negedge clk);
    check_eq("jmp_abort", 32'(read_en), 32'd0);
    check_eq("jmp_flush", 32'(ins_valid), 32'd0);
    for (int i = 0; i < 20 && !ins_valid; i++) @(negedge clk);
    check_eq("jmp_valid", 32'(ins_valid), 32'd1);
    check_eq("jmp_pc", 32'(ins_pc), 32'h0100);
    check_eq("jmp_data", 32'(ins_data), 32'(mem_byte(16'h0100)));

    // Back-to-back jumps (last wins) into the address wrap
    @(posedge clk); #1;
    jump_en = 1'b1;
    jump_addr = 16'h0200;
    @(posedge clk); #1;
    jump_addr = 16'hFFFE;
    @(posedge clk); #1;
    jump_en = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("wrap_idle", 32'(read_en), 32'd0);
    check_eq("wrap_valid", 32'(ins_valid), 32'd1);
    @(posedge clk); #1;
    ins_ready = 1'b1;
    wpc = 16'hFFFE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("wrap_pc", 32'(ins_pc), 32'(wpc));
      wpc = wpc + 16'h0001;
    end
    @(posedge clk); #1;
    ins_ready = 1'b0;

    // fetch_hold raised during the wait cycle of a read
    do_jump(16'h0040);
    for (int i = 0; i < 20 && !read_en; i++) @(negedge clk);
    check_eq("hold_rd_addr", 32'(addr_bus), 32'h0040);
    @(posedge clk); #1;
    fetch_hold = 1'b1;
    @(negedge clk);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (read_en) n++;
    end
    check_eq("hold_no_rd", 32'(n), 32'd0);
    check_eq("hold_valid", 32'(ins_valid), 32'd1);
    check_eq("hold_pc", 32'(ins_pc), 32'h0040);
    check_eq("hold_data", 32'(ins_data), 32'(mem_byte(16'h0040)));
    @(posedge clk); #1;
    fetch_hold = 1'b0;
    for (int i = 0; i < 20 && !read_en; i++) @(negedge clk);
    check_eq("hold_resume", 32'(read_en), 32'd1);
    check_eq("hold_resume_addr", 32'(addr_bus), 32'h0041);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 200 && !z_done; i++) @(negedge clk);
    check_eq("ws0_done", 32'(z_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
